univ_shift_reg: RTL and testbench

//   Parametrised universal shift register: the successor to the fixed 8-bit serial

---
 rtl/univ_shift_reg.sv | 98 +++++++++
 tb/tb_univ_shift_reg.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with counted burst-shift engine
// Hold/shift/rotate/load per cycle in IDLE; BUSY repeats a latched shift mode cnt times.
`timescale 1ns/1ps
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [2:0]       mode_i,
    input  logic             sr_in_i,
    input  logic [WIDTH-1:0] par_in_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [WIDTH-1:0] q_o,
    output logic             sr_out_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_ROL  = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_LOAD = 3'b101;

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [2:0]       mode_lat_q;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic             done_q;
    logic [2:0]       eff_mode;
    logic             is_shift;

    // During a burst the latched mode drives both the datapath and sr_out.
    always_comb begin
        eff_mode = (state_q == S_BUSY) ? mode_lat_q : mode_i;
        is_shift = (mode_i == M_SHL) || (mode_i == M_SHR) ||
                   (mode_i == M_ROL) || (mode_i == M_ROR);
        q_d = q_q;
        case (eff_mode)
            M_SHL:   q_d = {q_q[WIDTH-2:0], sr_in_i};
            M_SHR:   q_d = {sr_in_i, q_q[WIDTH-1:1]};
            M_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            M_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
            M_LOAD:  q_d = par_in_i;
            default: q_d = q_q;
        endcase
        sr_out_o = ((eff_mode == M_SHL) || (eff_mode == M_ROL)) ? q_q[WIDTH-1] : q_q[0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            q_q        <= '0;
            mode_lat_q <= M_HOLD;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // The accepting edge only latches; the first shift happens next edge.
                    if (start_i && (cnt_i != '0) && is_shift) begin
                        mode_lat_q <= mode_i;
                        count_q    <= cnt_i;
                        busy_q     <= 1'b1;
                        state_q    <= S_BUSY;
                    end else begin
                        q_q <= q_d;
                    end
                end
                S_BUSY: begin
                    q_q     <= q_d;
                    count_q <= count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        mode_lat_q <= M_HOLD;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign q_o    = q_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - directed self-checking bench for univ_shift_reg
`timescale 1ns/1ps
module tb_univ_shift_reg;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_ROL  = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_LOAD = 3'b101;

    logic       clk;
    logic       rst_n;
    logic [2:0] mode;
    logic       sr_in;
    logic [7:0] par_in;
    logic       start;
    logic [3:0] cnt;
    logic [7:0] q;
    logic       sr_out;
    logic       busy;
    logic       done;

    int total  = 0;
    int passed = 0;

    univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .mode_i   (mode),
        .sr_in_i  (sr_in),
        .par_in_i (par_in),
        .start_i  (start),
        .cnt_i    (cnt),
        .q_o      (q),
        .sr_out_o (sr_out),
        .busy_o   (busy),
        .done_o   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One rising edge, then settle 1 ns so outputs are sampled clear of the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        mode   = M_HOLD;
        sr_in  = 1'b0;
        par_in = 8'h00;
        start  = 1'b0;
        cnt    = 4'd0;
        #12;
        check("reset_q", 32'(q), 32'h00);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // 1. asynchronous reset between edges
        mode = M_LOAD; par_in = 8'hA5;
        step();
        check("load_a5", 32'(q), 32'hA5);
        mode = M_HOLD;
        #3 rst_n = 1'b0;
        #2;
        check("async_q", 32'(q), 32'h00);
        check("async_busy", 32'(busy), 32'd0);
        #1 rst_n = 1'b1;

        // 2. serial walk left then right
        mode = M_SHL; sr_in = 1'b1;
        step();
        sr_in = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("shl_walk_q", 32'(q), 32'h80);
        check("shl_walk_srout", 32'(sr_out), 32'd1);
        mode = M_SHR; sr_in = 1'b1;
        step();
        sr_in = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("shr_walk_q", 32'(q), 32'h01);
        check("shr_walk_srout", 32'(sr_out), 32'd1);

        // 3. rotate identity
        mode = M_LOAD; par_in = 8'h3C;
        step();
        mode = M_ROL;
        for (int i = 0; i < 8; i++) step();
        check("rol8_q", 32'(q), 32'h3C);
        mode = M_ROR;
        step();
        check("ror1_q", 32'(q), 32'h1E);

        // 4. ROL burst of 3 with mode/par_in disturbed while busy
        mode = M_LOAD; par_in = 8'h81;
        step();
        mode = M_ROL; start = 1'b1; cnt = 4'd3;
        step();
        check("burst_e0_q", 32'(q), 32'h81);
        check("burst_e0_busy", 32'(busy), 32'd1);
        mode = M_LOAD; par_in = 8'hFF; start = 1'b0;
        step();
        check("burst_e1_q", 32'(q), 32'h03);
        check("burst_e1_srout", 32'(sr_out), 32'd0);
        check("burst_e1_done", 32'(done), 32'd0);
        step();
        check("burst_e2_q", 32'(q), 32'h06);
        check("burst_e2_busy", 32'(busy), 32'd1);
        mode = M_HOLD;
        step();
        check("burst_e3_q", 32'(q), 32'h0C);
        check("burst_e3_busy", 32'(busy), 32'd0);
        check("burst_e3_done", 32'(done), 32'd1);
        step();
        check("burst_e4_done", 32'(done), 32'd0);
        check("burst_e4_q", 32'(q), 32'h0C);

        // 5. reset in the middle of an SHR burst of 10
        mode = M_SHR; sr_in = 1'b1; start = 1'b1; cnt = 4'd10;
        step();
        check("rst_burst_e0_busy", 32'(busy), 32'd1);
        start = 1'b0; mode = M_HOLD;
        for (int i = 0; i < 4; i++) step();
        check("rst_burst_4_q", 32'(q), 32'hF0);
        check("rst_burst_4_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_q", 32'(q), 32'h00);
        check("midrst_busy", 32'(busy), 32'd0);
        #2 rst_n = 1'b1;
        sr_in = 1'b0;
        step();
        check("after_rst_done", 32'(done), 32'd0);
        step();
        check("after_rst_q", 32'(q), 32'h00);
        check("after_rst_busy", 32'(busy), 32'd0);

        // 6a. start with cnt=0 is an ordinary shift
        mode = M_LOAD; par_in = 8'h55;
        step();
        mode = M_SHL; sr_in = 1'b0; start = 1'b1; cnt = 4'd0;
        step();
        check("cnt0_q", 32'(q), 32'hAA);
        check("cnt0_busy", 32'(busy), 32'd0);
        // start with a non-shift mode is not a burst either
        mode = M_LOAD; par_in = 8'hAA; cnt = 4'd3;
        step();
        check("load_start_busy", 32'(busy), 32'd0);

        // 6b. back-to-back bursts: SHR x1 then ROR x2 started on the done cycle
        mode = M_SHR; sr_in = 1'b0; start = 1'b1; cnt = 4'd1;
        step();
        check("b2b_e0_busy", 32'(busy), 32'd1);
        check("b2b_e0_q", 32'(q), 32'hAA);
        step();
        check("b2b_e1_q", 32'(q), 32'h55);
        check("b2b_e1_done", 32'(done), 32'd1);
        mode = M_ROR; cnt = 4'd2;
        step();
        check("b2b_e2_q", 32'(q), 32'h55);
        check("b2b_e2_busy", 32'(busy), 32'd1);
        check("b2b_e2_done", 32'(done), 32'd0);
        start = 1'b0; mode = M_HOLD;
        step();
        check("b2b_e3_q", 32'(q), 32'hAA);
        step();
        check("b2b_e4_q", 32'(q), 32'h55);
        check("b2b_e4_done", 32'(done), 32'd1);
        step();
        check("b2b_e5_done", 32'(done), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
